// File: rtl/pg_frame_tx.sv
// Serial transmitter for the 7-bit parity-generator output: start, 7 data bits LSB-first, parity, stop.
// Also flags a one-cycle parity_err when the supplied P disagrees with the XOR of x.
module pg_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] x,
  input  logic       P,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       parity_err
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [6:0]    r_sr;
  logic          r_par;
  logic          r_tx;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_perr;

  logic w_accept;
  logic w_bit_end;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_bit_end = (r_cnt == CNT_MAX);

  assign in_ready   = r_in_ready;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign parity_err = r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sr       <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_perr <= 1'b0;

      // Bit-period counter runs in every non-idle state and wraps at each bit boundary.
      if (r_state != S_IDLE) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sr       <= x;
            r_par      <= P;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_perr     <= (P != (^x));
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_tx    <= r_sr[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_idx == 3'd6) begin
              r_state <= S_PARITY;
              r_tx    <= r_par;
            end else begin
              r_idx <= r_idx + 3'd1;
              r_sr  <= r_sr >> 1;
              r_tx  <= r_sr[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_done     <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx       <= 1'b1;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pg_frame_tx.sv
// Directed bench for pg_frame_tx: instance A at CLKS_PER_BIT=4, instance B at CLKS_PER_BIT=1.
module tb_pg_frame_tx;

  localparam int unsigned CPB_A = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] xa, xb;
  logic       pa, pb, va, vb;
  logic       a_rdy, a_tx, a_busy, a_done, a_perr;
  logic       b_rdy, b_tx, b_busy, b_done, b_perr;

  int checks = 0;
  int errors = 0;

  pg_frame_tx #(.CLKS_PER_BIT(CPB_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .x(xa), .P(pa), .in_valid(va),
    .in_ready(a_rdy), .tx(a_tx), .busy(a_busy), .done(a_done), .parity_err(a_perr)
  );

  pg_frame_tx #(.CLKS_PER_BIT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .x(xb), .P(pb), .in_valid(vb),
    .in_ready(b_rdy), .tx(b_tx), .busy(b_busy), .done(b_done), .parity_err(b_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in cycle 0 (just after the acceptance edge); returns in cycle 10*CPB (the done cycle).
  task automatic frame_a(input logic [6:0] xv, input logic pv, input logic perr_exp,
                         input logic [6:0] nx, input logic np);
    logic [9:0] bits;
    bits = {1'b1, pv, xv, 1'b0};
    chk("a_perr_c0", 32'(a_perr), 32'(perr_exp));
    for (int c = 0; c < 10 * CPB_A; c++) begin
      if (c == 1) begin xa = 7'h55; pa = ~pv; end
      if (c == 30) begin xa = nx; pa = np; end
      chk($sformatf("a_tx_x%02h_c%0d", xv, c), 32'(a_tx), 32'(bits[c / CPB_A]));
      chk($sformatf("a_status_c%0d", c), 32'({a_busy, a_rdy, a_done}), 32'(3'b100));
      if (c > 0) chk($sformatf("a_perr_c%0d", c), 32'(a_perr), 32'd0);
      step();
    end
    chk("a_done_end", 32'({a_done, a_rdy, a_busy, a_tx}), 32'(4'b1101));
  endtask

  initial begin
    logic [6:0] cap;
    logic       capp;

    rst_n = 1'b0;
    va = 1'b0; vb = 1'b0;
    xa = '0; pa = 1'b0; xb = '0; pb = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      xa = 7'($urandom); pa = 1'($urandom); va = 1'($urandom);
      xb = 7'($urandom); pb = 1'($urandom); vb = 1'($urandom);
      step();
      chk($sformatf("rst_a_%0d", i), 32'({a_tx, a_rdy, a_busy, a_done, a_perr}), 32'(5'b11000));
      chk($sformatf("rst_b_%0d", i), 32'({b_tx, b_rdy, b_busy, b_done, b_perr}), 32'(5'b11000));
    end
    va = 1'b0; vb = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_a", 32'({a_tx, a_rdy, a_busy, a_done}), 32'(4'b1100));

    // Single frame
    xa = 7'b0000001; pa = 1'b1; va = 1'b1;
    step();
    va = 1'b0;
    frame_a(7'b0000001, 1'b1, 1'b0, 7'h00, 1'b0);

    // Bad parity: four ones with P=1
    xa = 7'b1010101; pa = 1'b1; va = 1'b1;
    step();
    va = 1'b0;
    frame_a(7'b1010101, 1'b1, 1'b1, 7'h00, 1'b0);
    step();

    // Back-to-back with in_valid held; mid-frame x=55 must not leak
    xa = 7'h7F; pa = 1'b1; va = 1'b1;
    step();
    frame_a(7'h7F, 1'b1, 1'b0, 7'h00, 1'b0);
    step();
    va = 1'b0;
    frame_a(7'h00, 1'b0, 1'b0, 7'h00, 1'b0);
    step();

    // Reset during data bit 3
    xa = 7'b0110011; pa = 1'b0; va = 1'b1;
    step();
    va = 1'b0;
    for (int c = 0; c < 17; c++) step();
    chk("pre_rst_busy", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_a", 32'({a_tx, a_rdy, a_busy, a_done}), 32'(4'b1100));
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("midrst_hold_%0d", i), 32'({a_tx, a_busy, a_done}), 32'(3'b100));
    end
    rst_n = 1'b1;
    xa = 7'b1100110; pa = 1'b0; va = 1'b1;
    step();
    va = 1'b0;
    frame_a(7'b1100110, 1'b0, 1'b0, 7'h00, 1'b0);
    step();

    // Exhaustive sweep on the CPB=1 instance, back-to-back via the done cycle
    for (int v = 0; v < 128; v++) begin
      xb = 7'(v); pb = ^xb; vb = 1'b1;
      step();
      vb = 1'b0;
      cap = '0; capp = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (k == 0) chk($sformatf("b_start_%0d", v), 32'(b_tx), 32'd0);
        else if (k <= 7) cap[k-1] = b_tx;
        else if (k == 8) capp = b_tx;
        else chk($sformatf("b_stop_%0d", v), 32'(b_tx), 32'd1);
        chk($sformatf("b_perr_%0d_%0d", v, k), 32'(b_perr), 32'd0);
        step();
      end
      chk($sformatf("b_data_%0d", v), 32'(cap), 32'(v));
      chk($sformatf("b_par_%0d", v), 32'(capp), 32'(^(7'(v))));
      chk($sformatf("b_done_%0d", v), 32'({b_done, b_rdy}), 32'(2'b11));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
